// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding, PC mux and forwarding codes.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // PC source select
  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;  // PC+1
  localparam logic [1:0] PC_SEL_JUMP   = 2'b01;  // jump target
  localparam logic [1:0] PC_SEL_BRANCH = 2'b10;  // branch target
  localparam logic [1:0] PC_SEL_SYS    = 2'b11;  // SYS_pc_val

  // EX operand select
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // Reg_write_data (WB)
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALU_result_MEM

  // A producer/consumer register match. $0 is hard-wired zero, so it never
  // creates a dependency.
  function automatic logic reg_match(input logic en, input logic [4:0] dst, input logic [4:0] src);
    return en && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding select for one operand; the MEM-stage producer beats the WB-stage producer.
// Latency: purely combinational, result valid in the same cycle as the inputs.
// Backpressure: none; no handshake, evaluated every cycle.
// Ports: i_src (EX source reg), i_mem_we/i_mem_dst, i_wb_we/i_wb_dst (producers), o_sel (FWD_* code).
import pipe_pkg::*;

module fwd_unit (
  input  logic [4:0] i_src,
  input  logic       i_mem_we,
  input  logic [4:0] i_mem_dst,
  input  logic       i_wb_we,
  input  logic [4:0] i_wb_dst,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (reg_match(i_mem_we, i_mem_dst, i_src)) begin
      o_sel = FWD_MEM;
    end else if (reg_match(i_wb_we, i_wb_dst, i_src)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencer: PC/IF-ID gating, load-use bubbles, branch/jump flushes, forwarding, program-load mode.
// Latency: controls are combinational from state+inputs (same cycle); state/counter updates visible after next edge.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle; SYS_load holds the whole pipe while asserted.
// Ports: SYS_clk/SYS_reset (sync, active high), SYS_load/SYS_pc_val (program load), ID/EX/MEM/WB hazard inputs;
//        outputs pc_write/pc_sel, ifid_write, ifid/idex/exmem_flush, fwd_a/fwd_b, busy, stall_cnt/flush_cnt.
import pipe_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             SYS_load,
  input  logic [7:0]       SYS_pc_val,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             use_rs_ID,
  input  logic             use_rt_ID,
  input  logic             jump_ID,
  input  logic [4:0]       rs_EX,
  input  logic [4:0]       rt_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       dst_EX,
  input  logic             RegWrite_MEM,
  input  logic [4:0]       dst_MEM,
  input  logic             branch_taken_MEM,
  input  logic             RegWrite_WB,
  input  logic [4:0]       dst_WB,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_drain_cnt;
  logic [3:0]       w_drain_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_drain_done;
  logic             w_load_use;
  logic             w_ev_stall;
  logic             w_ev_flush;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_unused_pc_val;

  // The load PC value feeds the datapath PC mux directly; the controller
  // only selects it via pc_sel.
  assign w_unused_pc_val = ^SYS_pc_val;

  // Widened compare so DRAIN_CYC=0 and DRAIN_CYC=15 both behave.
  assign w_drain_done = ({1'b0, r_drain_cnt} + 5'd1) >= 5'(DRAIN_CYC);

  assign w_load_use = MemRead_EX &
                      (reg_match(use_rs_ID, dst_EX, rs_ID) | reg_match(use_rt_ID, dst_EX, rt_ID));

  // Next-state
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      ST_INIT, ST_DRAIN: begin
        if (SYS_load) begin
          w_state_nxt = ST_LOAD;
          w_drain_nxt = 4'd0;
        end else if (w_drain_done) begin
          w_state_nxt = ST_RUN;
          w_drain_nxt = 4'd0;
        end else begin
          w_drain_nxt = r_drain_cnt + 4'd1;
        end
      end
      ST_RUN: begin
        if (SYS_load) begin
          w_state_nxt = ST_LOAD;
          w_drain_nxt = 4'd0;
        end
      end
      ST_LOAD: begin
        if (!SYS_load) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_drain_nxt = 4'd0;
      end
    endcase
  end

  // Pipeline controls; RUN applies branch > load-use > jump priority.
  always_comb begin
    pc_write    = 1'b1;
    pc_sel      = PC_SEL_SEQ;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    w_ev_stall  = 1'b0;
    w_ev_flush  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (branch_taken_MEM) begin
          // Everything younger than MEM is on the wrong path, including
          // whatever hazard or jump it was carrying.
          pc_sel      = PC_SEL_BRANCH;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          w_ev_flush  = 1'b1;
        end else if (w_load_use) begin
          // Hold IF and ID, bubble EX; a jump in ID is retried next cycle.
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          w_ev_stall = 1'b1;
        end else if (jump_ID) begin
          pc_sel     = PC_SEL_JUMP;
          ifid_flush = 1'b1;
          w_ev_flush = 1'b1;
        end
      end
      ST_LOAD: begin
        pc_sel      = PC_SEL_SYS;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
      default: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
    endcase
  end

  fwd_unit u_fwd_a (
    .i_src    (rs_EX),
    .i_mem_we (RegWrite_MEM),
    .i_mem_dst(dst_MEM),
    .i_wb_we  (RegWrite_WB),
    .i_wb_dst (dst_WB),
    .o_sel    (w_fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_src    (rt_EX),
    .i_mem_we (RegWrite_MEM),
    .i_mem_dst(dst_MEM),
    .i_wb_we  (RegWrite_WB),
    .i_wb_dst (dst_WB),
    .o_sel    (w_fwd_b)
  );

  // Outside RUN the EX stage holds flushed NOPs, so forwarding is parked.
  assign fwd_a = (r_state == ST_RUN) ? w_fwd_a : FWD_RF;
  assign fwd_b = (r_state == ST_RUN) ? w_fwd_b : FWD_RF;
  assign busy  = (r_state != ST_RUN);

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      r_state     <= ST_INIT;
      r_drain_cnt <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (w_ev_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_ev_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios then random traffic, scoreboard of expected controls.
// A second instance with 3-bit counters shares all inputs so counter saturation is reached in a few cycles.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    bit         reset;
    bit         load;
    logic [7:0] pcv;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    bit         use_rs;
    bit         use_rt;
    bit         jump;
    logic [4:0] rs_ex;
    logic [4:0] rt_ex;
    bit         memrd;
    logic [4:0] dst_ex;
    bit         rw_mem;
    logic [4:0] dst_mem;
    bit         br;
    bit         rw_wb;
    logic [4:0] dst_wb;
  } stim_t;

  typedef struct {
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        busy;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [2:0]  sat_stall;
    logic [2:0]  sat_flush;
  } exp_t;

  localparam int MDL_RUN   = 1;
  localparam int MDL_INIT  = 0;
  localparam int MDL_LOAD  = 2;
  localparam int MDL_DRAIN = 3;

  logic        clk;
  logic        rst;
  logic        load;
  logic [7:0]  pc_val;
  logic [4:0]  rs_id, rt_id, rs_ex, rt_ex, dst_ex, dst_mem, dst_wb;
  logic        use_rs, use_rt, jump, memrd, rw_mem, br, rw_wb;

  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, busy;
  logic [1:0]  pc_sel, fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_exmem_flush, s_busy;
  logic [1:0]  s_pc_sel, s_fwd_a, s_fwd_b;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  // reference model state
  int m_st    = MDL_INIT;
  int m_drain = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_hazard_ctrl #(.DRAIN_CYC(3), .CNT_W(16)) dut (
    .SYS_clk(clk), .SYS_reset(rst), .SYS_load(load), .SYS_pc_val(pc_val),
    .rs_ID(rs_id), .rt_ID(rt_id), .use_rs_ID(use_rs), .use_rt_ID(use_rt), .jump_ID(jump),
    .rs_EX(rs_ex), .rt_EX(rt_ex), .MemRead_EX(memrd), .dst_EX(dst_ex),
    .RegWrite_MEM(rw_mem), .dst_MEM(dst_mem), .branch_taken_MEM(br),
    .RegWrite_WB(rw_wb), .dst_WB(dst_wb),
    .pc_write(pc_write), .pc_sel(pc_sel), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.DRAIN_CYC(3), .CNT_W(3)) dut_sat (
    .SYS_clk(clk), .SYS_reset(rst), .SYS_load(load), .SYS_pc_val(pc_val),
    .rs_ID(rs_id), .rt_ID(rt_id), .use_rs_ID(use_rs), .use_rt_ID(use_rt), .jump_ID(jump),
    .rs_EX(rs_ex), .rt_EX(rt_ex), .MemRead_EX(memrd), .dst_EX(dst_ex),
    .RegWrite_MEM(rw_mem), .dst_MEM(dst_mem), .branch_taken_MEM(br),
    .RegWrite_WB(rw_wb), .dst_WB(dst_wb),
    .pc_write(s_pc_write), .pc_sel(s_pc_sel), .ifid_write(s_ifid_write),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .busy(s_busy),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL cyc=%0d %s: got=%0h exp=%0h", cyc, tag, got, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic bit dep(input bit en, input logic [4:0] producer, input logic [4:0] consumer);
    if (!en) return 1'b0;
    if (producer == 5'd0) return 1'b0;
    return producer == consumer;
  endfunction

  function automatic logic [1:0] mdl_fwd(input stim_t s, input logic [4:0] src);
    if (dep(s.rw_mem, s.dst_mem, src)) return 2'b10;
    if (dep(s.rw_wb, s.dst_wb, src))   return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mdl_lu(input stim_t s);
    return s.memrd && (dep(s.use_rs, s.dst_ex, s.rs_id) || dep(s.use_rt, s.dst_ex, s.rt_id));
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic exp_t model_expect(input stim_t s);
    exp_t e;
    e.stall_cnt = 16'(m_stall);
    e.flush_cnt = 16'(m_flush);
    e.sat_stall = 3'(sat(m_stall, 7));
    e.sat_flush = 3'(sat(m_flush, 7));
    e.busy      = (m_st != MDL_RUN);
    e.fwd_a     = 2'b00;
    e.fwd_b     = 2'b00;
    if (m_st == MDL_RUN) begin
      e.fwd_a = mdl_fwd(s, s.rs_ex);
      e.fwd_b = mdl_fwd(s, s.rt_ex);
      if (s.br) begin
        e.pc_write = 1; e.pc_sel = 2'b10; e.ifid_write = 1;
        e.ifid_flush = 1; e.idex_flush = 1; e.exmem_flush = 1;
      end else if (mdl_lu(s)) begin
        e.pc_write = 0; e.pc_sel = 2'b00; e.ifid_write = 0;
        e.ifid_flush = 0; e.idex_flush = 1; e.exmem_flush = 0;
      end else if (s.jump) begin
        e.pc_write = 1; e.pc_sel = 2'b01; e.ifid_write = 1;
        e.ifid_flush = 1; e.idex_flush = 0; e.exmem_flush = 0;
      end else begin
        e.pc_write = 1; e.pc_sel = 2'b00; e.ifid_write = 1;
        e.ifid_flush = 0; e.idex_flush = 0; e.exmem_flush = 0;
      end
    end else begin
      e.pc_write = 1; e.ifid_write = 1;
      e.ifid_flush = 1; e.idex_flush = 1; e.exmem_flush = 1;
      e.pc_sel = (m_st == MDL_LOAD) ? 2'b11 : 2'b00;
    end
    return e;
  endfunction

  task automatic model_advance(input stim_t s);
    if (s.reset) begin
      m_st = MDL_INIT; m_drain = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (m_st == MDL_RUN) begin
      if (s.br)            m_flush = sat(m_flush + 1, 65535);
      else if (mdl_lu(s))  m_stall = sat(m_stall + 1, 65535);
      else if (s.jump)     m_flush = sat(m_flush + 1, 65535);
      if (s.load) begin m_st = MDL_LOAD; m_drain = 0; end
    end else if (m_st == MDL_LOAD) begin
      if (!s.load) begin m_st = MDL_DRAIN; m_drain = 0; end
    end else begin
      if (s.load) begin
        m_st = MDL_LOAD; m_drain = 0;
      end else if (m_drain == 2) begin
        m_st = MDL_RUN; m_drain = 0;
      end else begin
        m_drain++;
      end
    end
  endtask

  task automatic drive(input stim_t s);
    rst = s.reset; load = s.load; pc_val = s.pcv;
    rs_id = s.rs_id; rt_id = s.rt_id; use_rs = s.use_rs; use_rt = s.use_rt; jump = s.jump;
    rs_ex = s.rs_ex; rt_ex = s.rt_ex; memrd = s.memrd; dst_ex = s.dst_ex;
    rw_mem = s.rw_mem; dst_mem = s.dst_mem; br = s.br; rw_wb = s.rw_wb; dst_wb = s.dst_wb;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check("pc_write",    32'(pc_write),    32'(e.pc_write));
    check("pc_sel",      32'(pc_sel),      32'(e.pc_sel));
    check("ifid_write",  32'(ifid_write),  32'(e.ifid_write));
    check("ifid_flush",  32'(ifid_flush),  32'(e.ifid_flush));
    check("idex_flush",  32'(idex_flush),  32'(e.idex_flush));
    check("exmem_flush", 32'(exmem_flush), 32'(e.exmem_flush));
    check("fwd_a",       32'(fwd_a),       32'(e.fwd_a));
    check("fwd_b",       32'(fwd_b),       32'(e.fwd_b));
    check("busy",        32'(busy),        32'(e.busy));
    check("stall_cnt",   32'(stall_cnt),   32'(e.stall_cnt));
    check("flush_cnt",   32'(flush_cnt),   32'(e.flush_cnt));
    check("sat_stall",   32'(s_stall_cnt), 32'(e.sat_stall));
    check("sat_flush",   32'(s_flush_cnt), 32'(e.sat_flush));
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    cyc++;
    drive(s);
    sb_q.push_back(model_expect(s));
    @(negedge clk);
    compare_out();
    model_advance(s);
  endtask

  initial begin
    stim_t s;
    s = idle();
    s.reset = 1;
    drive(s);

    // reset for two cycles, then three drain cycles and into RUN
    step(s); step(s);
    s = idle();
    repeat (5) step(s);

    // load-use on rs; then the same with $0
    s = idle(); s.memrd = 1; s.dst_ex = 5'd2; s.use_rs = 1; s.rs_id = 5'd2; step(s);
    s.dst_ex = 5'd0; s.rs_id = 5'd0; step(s);
    // load-use on rt; then rt not read
    s = idle(); s.memrd = 1; s.dst_ex = 5'd7; s.use_rt = 1; s.rt_id = 5'd7; step(s);
    s.use_rt = 0; step(s);

    // forwarding: MEM beats WB, then WB alone, then $0
    s = idle(); s.rw_mem = 1; s.dst_mem = 5'd5; s.rw_wb = 1; s.dst_wb = 5'd5;
    s.rs_ex = 5'd5; s.rt_ex = 5'd5; step(s);
    s.rw_mem = 0; step(s);
    s.rs_ex = 5'd0; s.dst_wb = 5'd0; step(s);
    s = idle(); s.rw_mem = 1; s.dst_mem = 5'd3; s.rt_ex = 5'd3;
    s.rw_wb = 1; s.dst_wb = 5'd4; s.rs_ex = 5'd4; step(s);

    // branch beats concurrent load-use and jump
    s = idle(); s.br = 1; s.memrd = 1; s.dst_ex = 5'd2; s.use_rs = 1; s.rs_id = 5'd2; s.jump = 1; step(s);
    s = idle(); s.jump = 1; step(s);
    s.memrd = 1; s.dst_ex = 5'd9; s.use_rt = 1; s.rt_id = 5'd9; step(s);

    // program load from RUN, forwarding parked, then drain back to RUN
    s = idle(); s.load = 1; s.pcv = 8'h40; s.rw_mem = 1; s.dst_mem = 5'd1; s.rs_ex = 5'd1; s.jump = 1;
    repeat (3) step(s);
    s.load = 0;
    repeat (5) step(s);

    // load pre-empting a drain
    s = idle(); s.load = 1; step(s);
    s.load = 0; step(s); step(s);
    s.load = 1; step(s);
    s.load = 0; repeat (5) step(s);

    // push both counters past the small instance's ceiling
    s = idle(); s.memrd = 1; s.dst_ex = 5'd6; s.use_rs = 1; s.rs_id = 5'd6;
    repeat (10) step(s);
    s = idle(); s.jump = 1;
    repeat (9) step(s);

    // reset in RUN overrides a taken branch
    s = idle(); s.reset = 1; s.br = 1; step(s);
    s = idle(); repeat (5) step(s);

    // random traffic over a small register set to create frequent matches
    for (int i = 0; i < 400; i++) begin
      s = idle();
      s.reset   = ($urandom_range(0, 149) == 0);
      s.load    = ($urandom_range(0, 24) == 0);
      s.pcv     = 8'($urandom_range(0, 255));
      s.rs_id   = 5'($urandom_range(0, 3));
      s.rt_id   = 5'($urandom_range(0, 3));
      s.use_rs  = $urandom_range(0, 1) == 1;
      s.use_rt  = $urandom_range(0, 1) == 1;
      s.jump    = ($urandom_range(0, 3) == 0);
      s.rs_ex   = 5'($urandom_range(0, 3));
      s.rt_ex   = 5'($urandom_range(0, 3));
      s.memrd   = $urandom_range(0, 1) == 1;
      s.dst_ex  = 5'($urandom_range(0, 3));
      s.rw_mem  = $urandom_range(0, 1) == 1;
      s.dst_mem = 5'($urandom_range(0, 3));
      s.br      = ($urandom_range(0, 7) == 0);
      s.rw_wb   = $urandom_range(0, 1) == 1;
      s.dst_wb  = 5'($urandom_range(0, 3));
      step(s);
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
